// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance checker.
// Holds the controller FSM state encoding and the distance-width helper.
// No logic; imported by the checker top and its popcount sub-module.
package mhd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to hold a distance in the range 0..width inclusive.
   function automatic int hd_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the input vector.
//   i_vec : vector whose set bits are counted
//   o_cnt : number of set bits, HD_W bits wide
module mhd_popcount #(
   parameter int WIDTH = 16,
   parameter int HD_W  = 5
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [HD_W-1:0]  o_cnt
);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_cnt = o_cnt + HD_W'(i_vec[i]);
      end
   end

endmodule

// File: rtl/mhd_check_ctrl.sv
// Compares exact/approximate vector pairs, flags pairs whose Hamming distance exceeds MHD.
// Latency: results update 2 cycles after a transfer (S1 register, then evaluation edge).
// Backpressure: in_ready drops when the run quota is met or, with stop_on_fail, a failing pair sits in S1.
//   Ports: clk, rst (sync, active-high); start/num_vec/stop_on_fail run control;
//   in_valid/in_ready/a/b pair stream; busy/done status; fail, max_hd, fail_cnt,
//   eval_cnt, first_fail_idx results (held in DONE until the next start).
module mhd_check_ctrl
   import mhd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MHD   = 6,
   parameter int CNT_W = 16,
   localparam int HD_W = hd_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             stop_on_fail,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [HD_W-1:0]  max_hd,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] eval_cnt,
   output logic [CNT_W-1:0] first_fail_idx
);

   state_t             r_state;
   state_t             w_state_nxt;

   logic [CNT_W-1:0]   r_num_vec;
   logic               r_stop;
   logic [CNT_W-1:0]   r_acc_cnt;
   logic               r_s1_vld;
   logic [WIDTH-1:0]   r_s1_diff;

   logic [CNT_W-1:0]   r_eval_cnt;
   logic [CNT_W-1:0]   r_fail_cnt;
   logic               r_fail;
   logic [HD_W-1:0]    r_max_hd;
   logic [CNT_W-1:0]   r_first_fail_idx;

   logic [HD_W-1:0]    w_hd;
   logic               w_hd_fail;
   logic               w_in_ready;
   logic               w_xfer;
   logic               w_eval;
   logic               w_start_ok;
   logic [CNT_W-1:0]   w_eval_cnt_nxt;
   logic               w_fail_nxt;
   logic               w_drain;

   mhd_popcount #(
      .WIDTH (WIDTH),
      .HD_W  (HD_W)
   ) u_popcount (
      .i_vec (r_s1_diff),
      .o_cnt (w_hd)
   );

   // S1 only ever holds a pair while in RUN, so every valid S1 entry is
   // evaluated in the cycle after its transfer.
   assign w_eval     = (r_state == ST_RUN) && r_s1_vld;
   assign w_hd_fail  = w_eval && (int'(w_hd) > MHD);
   assign w_in_ready = (r_state == ST_RUN) && (r_acc_cnt < r_num_vec)
                       && !(r_stop && w_hd_fail);
   assign w_xfer     = in_valid && w_in_ready;
   assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // Post-update views used to leave RUN in the same edge as the last evaluation.
   assign w_eval_cnt_nxt = r_eval_cnt + CNT_W'(w_eval);
   assign w_fail_nxt     = r_fail || w_hd_fail;
   assign w_drain        = (w_eval_cnt_nxt == r_num_vec) || (r_stop && w_fail_nxt);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)   w_state_nxt = ST_RUN;
         ST_RUN:  if (w_drain) w_state_nxt = ST_DONE;
         ST_DONE: if (start)   w_state_nxt = ST_RUN;
         default:              w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_vec        <= '0;
         r_stop           <= 1'b0;
         r_acc_cnt        <= '0;
         r_s1_vld         <= 1'b0;
         r_s1_diff        <= '0;
         r_eval_cnt       <= '0;
         r_fail_cnt       <= '0;
         r_fail           <= 1'b0;
         r_max_hd         <= '0;
         r_first_fail_idx <= '0;
      end else if (w_start_ok) begin
         r_num_vec        <= num_vec;
         r_stop           <= stop_on_fail;
         r_acc_cnt        <= '0;
         r_s1_vld         <= 1'b0;
         r_eval_cnt       <= '0;
         r_fail_cnt       <= '0;
         r_fail           <= 1'b0;
         r_max_hd         <= '0;
         r_first_fail_idx <= '0;
      end else if (r_state == ST_RUN) begin
         r_s1_vld <= w_xfer;
         if (w_xfer) begin
            r_s1_diff <= a ^ b;
            r_acc_cnt <= r_acc_cnt + 1'b1;
         end
         if (w_eval) begin
            r_eval_cnt <= w_eval_cnt_nxt;
            if (w_hd > r_max_hd) begin
               r_max_hd <= w_hd;
            end
            if (w_hd_fail) begin
               r_fail_cnt <= r_fail_cnt + 1'b1;
               r_fail     <= 1'b1;
               if (!r_fail) begin
                  r_first_fail_idx <= r_eval_cnt;
               end
            end
         end
      end
   end

   // Status outputs are masked by rst so they read low during the reset cycle itself.
   assign in_ready       = w_in_ready && !rst;
   assign busy           = (r_state == ST_RUN) && !rst;
   assign done           = (r_state == ST_DONE) && !rst;
   assign fail           = r_fail;
   assign max_hd         = r_max_hd;
   assign fail_cnt       = r_fail_cnt;
   assign eval_cnt       = r_eval_cnt;
   assign first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_mhd_check_ctrl.sv
module tb_mhd_check_ctrl;

   localparam int WIDTH = 16;
   localparam int MHD   = 6;
   localparam int CNT_W = 16;
   localparam int HD_W  = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_vec = '0;
   logic             stop_on_fail = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic             fail;
   logic [HD_W-1:0]  max_hd;
   logic [CNT_W-1:0] fail_cnt;
   logic [CNT_W-1:0] eval_cnt;
   logic [CNT_W-1:0] first_fail_idx;

   int tests = 0;
   int fails = 0;

   mhd_check_ctrl #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .num_vec        (num_vec),
      .stop_on_fail   (stop_on_fail),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .a              (a),
      .b              (b),
      .busy           (busy),
      .done           (done),
      .fail           (fail),
      .max_hd         (max_hd),
      .fail_cnt       (fail_cnt),
      .eval_cnt       (eval_cnt),
      .first_fail_idx (first_fail_idx)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 idle, 1 run, 2 done; pending distance -1 when nothing waits.
   int m_mode = 0;
   int m_num = 0;
   bit m_stop = 0;
   int m_acc = 0;
   int m_pend = -1;
   int m_eval = 0;
   int m_fail_cnt = 0;
   bit m_fail = 0;
   int m_max = 0;
   int m_ffi = 0;
   bit m_chk = 0;

   always @(posedge clk) begin
      int hd;
      bit rdy;
      bit xfer;
      hd  = $countones(a ^ b);
      rdy = (m_mode == 1) && (m_acc < m_num) && !(m_stop && m_pend > MHD);
      if (rst) begin
         m_mode = 0; m_num = 0; m_stop = 0; m_acc = 0; m_pend = -1;
         m_eval = 0; m_fail_cnt = 0; m_fail = 0; m_max = 0; m_ffi = 0;
         m_chk = 1;
      end else if (m_mode != 1) begin
         if (start) begin
            m_mode = 1; m_num = int'(num_vec); m_stop = stop_on_fail;
            m_acc = 0; m_pend = -1; m_eval = 0; m_fail_cnt = 0;
            m_fail = 0; m_max = 0; m_ffi = 0;
         end
      end else begin
         xfer = in_valid && rdy;
         if (m_pend >= 0) begin
            if (m_pend > m_max) m_max = m_pend;
            if (m_pend > MHD) begin
               if (!m_fail) m_ffi = m_eval;
               m_fail = 1;
               m_fail_cnt++;
            end
            m_eval++;
         end
         if (m_eval == m_num || (m_stop && m_fail)) m_mode = 2;
         m_pend = xfer ? hd : -1;
         if (xfer) m_acc++;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_chk) begin
         bit e_rdy, e_busy, e_done, bad;
         e_rdy  = !rst && (m_mode == 1) && (m_acc < m_num) && !(m_stop && m_pend > MHD);
         e_busy = !rst && (m_mode == 1);
         e_done = !rst && (m_mode == 2);
         bad = (in_ready !== e_rdy) || (busy !== e_busy) || (done !== e_done)
               || (fail !== m_fail) || (int'(max_hd) != m_max)
               || (int'(fail_cnt) != m_fail_cnt) || (int'(eval_cnt) != m_eval)
               || (int'(first_fail_idx) != m_ffi) || $isunknown({in_ready, busy, done, fail});
         tests++;
         if (bad) begin
            fails++;
            $display("FAIL cycle_model t=%0t got rdy=%b busy=%b done=%b fail=%b max=%0d fcnt=%0d ecnt=%0d ffi=%0d want rdy=%b busy=%b done=%b fail=%b max=%0d fcnt=%0d ecnt=%0d ffi=%0d",
                     $time, in_ready, busy, done, fail, max_hd, fail_cnt, eval_cnt, first_fail_idx,
                     e_rdy, e_busy, e_done, m_fail, m_max, m_fail_cnt, m_eval, m_ffi);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] mask_of(input int d);
      logic [31:0] m;
      m = (32'd1 << d) - 32'd1;
      return m[WIDTH-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n, input bit stop);
      start = 1'b1;
      num_vec = CNT_W'(n);
      stop_on_fail = stop;
      tick();
      start = 1'b0;
   endtask

   // Present a pair of distance d and hold it until it is taken; leaves in_valid high.
   task automatic send(input int d);
      bit ok;
      int n;
      a = WIDTH'($urandom);
      b = a ^ mask_of(d);
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = in_ready;
         tick();
         n++;
      end while (!ok && n < 40);
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout got in_ready=0 want transfer within 40 cycles");
      end
   endtask

   task automatic wait_done();
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 60) begin
         @(negedge clk);
         seen = done;
         tick();
         n++;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL done_timeout got done=0 want done within 60 cycles");
      end
   endtask

   int d_eval, d_fcnt, d_max, d_ffi, d_fail;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ready", int'(in_ready), 0);
      chk("reset_eval", int'(eval_cnt), 0);
      tick();

      // Distances 0,6,7,16 back-to-back: 6 passes (boundary), 7 fails.
      do_start(4, 0);
      send(0); send(6); send(7); send(16);
      in_valid = 1'b0;
      wait_done();
      chk("a_eval", int'(eval_cnt), 4);
      chk("a_fcnt", int'(fail_cnt), 2);
      chk("a_max", int'(max_hd), 16);
      chk("a_ffi", int'(first_fail_idx), 2);
      chk("a_fail", int'(fail), 1);

      // Stop on first failure with the next pair held on the bus.
      do_start(5, 1);
      send(3); send(9);
      a = 16'h00F0;
      b = 16'h00F1;
      @(negedge clk);
      chk("b_ready_blocked", int'(in_ready), 0);
      tick();
      repeat (6) tick();
      in_valid = 1'b0;
      chk("b_done", int'(done), 1);
      chk("b_eval", int'(eval_cnt), 2);
      chk("b_fcnt", int'(fail_cnt), 1);
      chk("b_ffi", int'(first_fail_idx), 1);
      chk("b_max", int'(max_hd), 9);

      // Empty run.
      do_start(0, 0);
      @(negedge clk);
      chk("c_busy", int'(busy), 1);
      chk("c_ready", int'(in_ready), 0);
      tick();
      @(negedge clk);
      chk("c_done", int'(done), 1);
      chk("c_fail", int'(fail), 0);
      chk("c_eval", int'(eval_cnt), 0);
      chk("c_max", int'(max_hd), 0);
      tick();

      // Gap-free reference run.
      do_start(3, 0);
      send(2); send(7); send(5);
      in_valid = 1'b0;
      wait_done();
      d_eval = int'(eval_cnt); d_fcnt = int'(fail_cnt); d_max = int'(max_hd);
      d_ffi = int'(first_fail_idx); d_fail = int'(fail);

      // Same pairs with gaps and a start pulse mid-run.
      do_start(3, 0);
      send(2);
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      send(7);
      in_valid = 1'b0;
      tick();
      send(5);
      in_valid = 1'b0;
      wait_done();
      chk("e_eval", int'(eval_cnt), 3);
      chk("e_fcnt", int'(fail_cnt), 1);
      chk("e_ffi", int'(first_fail_idx), 1);
      chk("e_max", int'(max_hd), 7);
      chk("e_eval_vs_gapfree", int'(eval_cnt), d_eval);
      chk("e_fcnt_vs_gapfree", int'(fail_cnt), d_fcnt);
      chk("e_max_vs_gapfree", int'(max_hd), d_max);
      chk("e_ffi_vs_gapfree", int'(first_fail_idx), d_ffi);
      chk("e_fail_vs_gapfree", int'(fail), d_fail);

      // Mid-run reset, with start asserted alongside it.
      do_start(4, 0);
      send(8); send(2);
      in_valid = 1'b0;
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("f_busy_in_rst", int'(busy), 0);
      chk("f_ready_in_rst", int'(in_ready), 0);
      tick();
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("f_busy", int'(busy), 0);
      chk("f_done", int'(done), 0);
      chk("f_eval", int'(eval_cnt), 0);
      chk("f_fail", int'(fail), 0);
      chk("f_max", int'(max_hd), 0);
      tick();
      do_start(1, 0);
      send(7);
      in_valid = 1'b0;
      wait_done();
      chk("g_fail", int'(fail), 1);
      chk("g_fcnt", int'(fail_cnt), 1);
      chk("g_ffi", int'(first_fail_idx), 0);
      chk("g_eval", int'(eval_cnt), 1);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
